// File: rtl/floo_vc_credit_selector.sv
// Per-output-port credit counters with a per-preferred-VC pre-selection of a VC that has credit.
// Latency: credit/consume sampled at an edge are visible on counters and selection after that edge.
// Backpressure: none; consuming a VC without credit (and without a same-cycle credit) flags err_o.
module floo_vc_credit_selector #(
    parameter int unsigned NumVC         = 4,
    parameter int unsigned NumVCWidth    = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int unsigned NumVCWidthMax = 2,
    parameter int unsigned VCDepth       = 3,
    parameter int unsigned CreditWidth   = $clog2(VCDepth + 1),
    parameter bit          AllowFallback = 1'b1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       credit_v_i,
    input  logic [NumVCWidthMax-1:0]                   credit_id_i,
    input  logic                                       consume_v_i,
    input  logic [NumVCWidthMax-1:0]                   consume_id_i,
    output logic [NumVC-1:0]                           vc_selection_v_o,
    output logic [NumVC-1:0][NumVCWidthMax-1:0]        vc_selection_id_o,
    output logic [NumVC-1:0][CreditWidth-1:0]          credit_cnt_o,
    output logic                                       err_o
);

    // Reset value of every counter: the full downstream buffer is free.
    localparam logic [CreditWidth-1:0] FullCnt = CreditWidth'(VCDepth);
    localparam logic [CreditWidth-1:0] OneCnt  = CreditWidth'(1);

    logic [NumVC-1:0][CreditWidth-1:0] cnt_q, cnt_d;
    logic                              err_q, err_d;

    // Decoded per-VC events and per-VC error causes.
    logic [NumVC-1:0] inc, dec;
    logic [NumVC-1:0] overflow, underflow;
    logic             credit_oob, consume_oob;

    // Fallback candidate shared by all preferred ids: largest count, lowest index on ties.
    logic [NumVCWidth-1:0]  best_idx;
    logic [CreditWidth-1:0] best_cnt;

    // Range check uses the full port width; ids outside the VC range never match a counter.
    always_comb begin
        credit_oob  = credit_v_i  && (32'(credit_id_i)  >= NumVC);
        consume_oob = consume_v_i && (32'(consume_id_i) >= NumVC);
    end

    // One-hot decode of the returned credit and the departing flit onto the VC counters.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            inc[v] = credit_v_i  && (32'(credit_id_i)  == v);
            dec[v] = consume_v_i && (32'(consume_id_i) == v);
        end
    end

    // Counter next state; a same-cycle credit and consume cancel out even at zero
    // (the downstream shortcut), otherwise saturate and report the protocol violation.
    always_comb begin
        cnt_d     = cnt_q;
        overflow  = '0;
        underflow = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (inc[v] && !dec[v]) begin
                if (cnt_q[v] == FullCnt) begin
                    overflow[v] = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + OneCnt;
                end
            end else if (dec[v] && !inc[v]) begin
                if (cnt_q[v] == '0) begin
                    underflow[v] = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] - OneCnt;
                end
            end
        end
    end

    // Sticky error: once set it only clears through reset.
    always_comb begin
        err_d = err_q | (|overflow) | (|underflow) | credit_oob | consume_oob;
    end

    // Counter and error state; reset discards anything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                cnt_q[v] <= FullCnt;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Scan for the VC with the most credit; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_cnt = cnt_q[0];
        for (int unsigned v = 1; v < NumVC; v++) begin
            if (cnt_q[v] > best_cnt) begin
                best_idx = NumVCWidth'(v);
                best_cnt = cnt_q[v];
            end
        end
    end

    // Per preferred id: keep it if it has credit, else optionally fall back to the best VC.
    // Selection looks only at registered counters, so credits arriving now count next cycle.
    always_comb begin
        vc_selection_v_o  = '0;
        vc_selection_id_o = '0;
        for (int unsigned p = 0; p < NumVC; p++) begin
            vc_selection_id_o[p] = NumVCWidthMax'(p);
            if (cnt_q[p] != '0) begin
                vc_selection_v_o[p] = 1'b1;
            end else if (AllowFallback && (best_cnt != '0)) begin
                vc_selection_v_o[p]  = 1'b1;
                vc_selection_id_o[p] = NumVCWidthMax'(best_idx);
            end
        end
    end

    assign credit_cnt_o = cnt_q;
    assign err_o        = err_q;

endmodule
